// File: rtl/io_keys_conditioner_if.sv
// Key-conditioner bus: raw pins and clear mask in, the LSU-facing key word out.
interface io_keys_conditioner_if #(
  parameter int unsigned NUM_KEYS = 4
);
  logic [NUM_KEYS-1:0] keys_raw;
  logic [NUM_KEYS-1:0] i_clr;
  logic [31:0]         io_keys_o;

  modport master (output keys_raw, output i_clr, input io_keys_o);
  modport slave  (input keys_raw, input i_clr, output io_keys_o);
endinterface

// File: rtl/io_keys_conditioner.sv
// Synchronises, debounces and normalises board push-buttons, with sticky per-key press flags
// that software clears through a mask. Output word: levels in [NUM_KEYS-1:0], flags at bit 16.
module io_keys_conditioner #(
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned ACTIVE_LOW      = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  io_keys_conditioner_if.slave bus
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [NUM_KEYS-1:0] IdleRaw = (ACTIVE_LOW != 0) ? {NUM_KEYS{1'b1}}
                                                              : {NUM_KEYS{1'b0}};

  logic [NUM_KEYS-1:0] sync1_q, sync1_d;
  logic [NUM_KEYS-1:0] sync2_q, sync2_d;
  logic [NUM_KEYS-1:0] lvl_q, lvl_d;
  logic [NUM_KEYS-1:0] flag_q, flag_d;
  logic [CntW-1:0]     cnt_q [NUM_KEYS];
  logic [CntW-1:0]     cnt_d [NUM_KEYS];
  logic [NUM_KEYS-1:0] pressed;
  logic [NUM_KEYS-1:0] accept;
  logic [31:0]         keys_word;

  always_comb begin
    sync1_d = bus.keys_raw;
    sync2_d = sync1_q;
    pressed = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;
    lvl_d   = lvl_q;
    flag_d  = flag_q;
    accept  = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      cnt_d[k] = '0;
      if (pressed[k] != lvl_q[k]) begin
        if (cnt_q[k] == CntMax) begin
          accept[k] = 1'b1;
          lvl_d[k]  = pressed[k];
        end else begin
          cnt_d[k] = cnt_q[k] + 1'b1;
        end
      end
      // An accepted press beats a clear on the same edge; releases leave the flag alone.
      if (accept[k] && pressed[k]) begin
        flag_d[k] = 1'b1;
      end else if (bus.i_clr[k]) begin
        flag_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= IdleRaw;
      sync2_q <= IdleRaw;
      lvl_q   <= '0;
      flag_q  <= '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      lvl_q   <= lvl_d;
      flag_q  <= flag_d;
      for (int k = 0; k < NUM_KEYS; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  always_comb begin
    keys_word                  = '0;
    keys_word[NUM_KEYS-1:0]    = lvl_q;
    keys_word[16 +: NUM_KEYS]  = flag_q;
  end

  assign bus.io_keys_o = keys_word;

endmodule

// File: tb/tb_io_keys_conditioner.sv
// Bench for io_keys_conditioner: directed scenarios plus random key traffic against a
// sliding-window reference model of the debounced levels and sticky flags.
module tb_io_keys_conditioner;

  localparam int unsigned NK = 4;
  localparam int unsigned DB = 8;
  localparam int unsigned AL = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  io_keys_conditioner_if #(.NUM_KEYS(NK)) bus ();

  io_keys_conditioner #(
    .NUM_KEYS       (NK),
    .DEBOUNCE_CYCLES(DB),
    .ACTIVE_LOW     (AL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pressed values reach the debouncer two edges after sampling; a key's
  // level flips once the last DB values it saw all disagree with the current level.
  logic [NK-1:0] m_dly [2];
  logic [NK-1:0] m_win [$];
  logic [NK-1:0] m_lvl;
  logic [NK-1:0] m_flag;

  function automatic logic [NK-1:0] pressed_of(logic [NK-1:0] raw);
    return (AL != 0) ? ~raw : raw;
  endfunction

  function automatic logic [31:0] m_out();
    logic [31:0] o;
    o          = '0;
    o[NK-1:0]  = m_lvl;
    o[16 +: NK] = m_flag;
    return o;
  endfunction

  task automatic m_reset();
    m_dly[0] = '0;
    m_dly[1] = '0;
    m_win.delete();
    for (int i = 0; i < DB; i++) m_win.push_back('0);
    m_lvl  = '0;
    m_flag = '0;
  endtask

  task automatic m_edge();
    logic [NK-1:0] p;
    logic [NK-1:0] old_lvl;
    bit            all_diff;
    p        = m_dly[0];
    m_dly[0] = m_dly[1];
    m_dly[1] = pressed_of(bus.keys_raw);
    void'(m_win.pop_front());
    m_win.push_back(p);
    old_lvl = m_lvl;
    for (int k = 0; k < NK; k++) begin
      all_diff = 1'b1;
      foreach (m_win[i]) if (m_win[i][k] == old_lvl[k]) all_diff = 1'b0;
      if (all_diff) m_lvl[k] = ~old_lvl[k];
      if (all_diff && m_lvl[k]) m_flag[k] = 1'b1;
      else if (bus.i_clr[k]) m_flag[k] = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) m_reset();
    else m_edge();
    #1;
  endtask

  task automatic test_reset();
    bus.keys_raw = '1;
    bus.i_clr    = '0;
    #1 rst_n = 1'b0;
    m_reset();
    #1;
    checks++;
    if (bus.io_keys_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_state got %h exp %h", bus.io_keys_o, 32'h0);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      checks++;
      if (bus.io_keys_o !== 32'h0) begin
        errors++;
        $display("FAIL idle_after_reset cyc %0d got %h exp %h", i, bus.io_keys_o, 32'h0);
      end
    end
  endtask

  task automatic test_press_latency();
    bus.keys_raw[0] = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      checks++;
      if (bus.io_keys_o !== m_out()) begin
        errors++;
        $display("FAIL press_model edge %0d got %h exp %h", e, bus.io_keys_o, m_out());
      end
      if (e == 9) begin
        checks++;
        if (bus.io_keys_o !== 32'h0) begin
          errors++;
          $display("FAIL press_edge9 got %h exp %h", bus.io_keys_o, 32'h0);
        end
      end
      if (e == 10) begin
        checks++;
        if (bus.io_keys_o !== 32'h0001_0001) begin
          errors++;
          $display("FAIL press_edge10 got %h exp %h", bus.io_keys_o, 32'h0001_0001);
        end
      end
    end
  endtask

  task automatic test_bounce();
    int n;
    for (int r = 0; r < 12; r++) begin
      n = (r == 0) ? 7 : 3;
      bus.keys_raw[1] = 1'b0;
      for (int i = 0; i < n; i++) begin
        tick();
        checks++;
        if (bus.io_keys_o[1] !== 1'b0 || bus.io_keys_o[17] !== 1'b0
            || bus.io_keys_o !== m_out()) begin
          errors++;
          $display("FAIL bounce r%0d got %h exp %h", r, bus.io_keys_o, m_out());
        end
      end
      bus.keys_raw[1] = 1'b1;
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) tick();
    end
    for (int i = 0; i < DB + 4; i++) begin
      tick();
      checks++;
      if (bus.io_keys_o[1] !== 1'b0 || bus.io_keys_o[17] !== 1'b0) begin
        errors++;
        $display("FAIL bounce_settle got %h exp bits1/17 clear", bus.io_keys_o);
      end
    end
  endtask

  task automatic test_release_clear();
    bus.keys_raw[0] = 1'b1;
    for (int e = 1; e <= DB + 2; e++) tick();
    checks++;
    if (bus.io_keys_o !== 32'h0001_0000) begin
      errors++;
      $display("FAIL release_keeps_flag got %h exp %h", bus.io_keys_o, 32'h0001_0000);
    end
    bus.i_clr = 4'h1;
    tick();
    bus.i_clr = 4'h0;
    checks++;
    if (bus.io_keys_o !== 32'h0) begin
      errors++;
      $display("FAIL clear_flag got %h exp %h", bus.io_keys_o, 32'h0);
    end
    tick();
    checks++;
    if (bus.io_keys_o !== m_out()) begin
      errors++;
      $display("FAIL clear_model got %h exp %h", bus.io_keys_o, m_out());
    end
  endtask

  task automatic test_clr_held();
    bus.i_clr[2]    = 1'b1;
    bus.keys_raw[2] = 1'b0;
    for (int e = 1; e <= 11; e++) begin
      tick();
      checks++;
      if (bus.io_keys_o !== m_out()) begin
        errors++;
        $display("FAIL clr_held_model edge %0d got %h exp %h", e, bus.io_keys_o, m_out());
      end
      if (e == 10) begin
        checks++;
        if (bus.io_keys_o !== 32'h0004_0004) begin
          errors++;
          $display("FAIL clr_held_set got %h exp %h", bus.io_keys_o, 32'h0004_0004);
        end
      end
      if (e == 11) begin
        checks++;
        if (bus.io_keys_o !== 32'h0000_0004) begin
          errors++;
          $display("FAIL clr_held_clear got %h exp %h", bus.io_keys_o, 32'h0000_0004);
        end
      end
    end
    bus.i_clr = '0;
  endtask

  task automatic test_reset_mid();
    bus.keys_raw = 4'b0110;
    for (int e = 1; e <= 7; e++) tick();
    #2 rst_n = 1'b0;
    m_reset();
    #1;
    checks++;
    if (bus.io_keys_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_clear got %h exp %h", bus.io_keys_o, 32'h0);
    end
    tick();
    rst_n = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      checks++;
      if (bus.io_keys_o !== m_out()) begin
        errors++;
        $display("FAIL reset_mid_model edge %0d got %h exp %h", e, bus.io_keys_o, m_out());
      end
      if (e == 9) begin
        checks++;
        if (bus.io_keys_o !== 32'h0) begin
          errors++;
          $display("FAIL reset_mid_edge9 got %h exp %h", bus.io_keys_o, 32'h0);
        end
      end
      if (e == 10) begin
        checks++;
        if (bus.io_keys_o !== 32'h0009_0009) begin
          errors++;
          $display("FAIL reset_mid_edge10 got %h exp %h", bus.io_keys_o, 32'h0009_0009);
        end
      end
    end
  endtask

  task automatic test_random();
    int hold [NK];
    for (int k = 0; k < NK; k++) hold[k] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NK; k++) begin
        if (hold[k] == 0) begin
          bus.keys_raw[k] = 1'($urandom_range(0, 1));
          hold[k] = $urandom_range(1, 14);
        end else begin
          hold[k]--;
        end
        bus.i_clr[k] = ($urandom_range(0, 7) == 0);
      end
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        m_reset();
        tick();
        rst_n = 1'b1;
      end
      tick();
      checks++;
      if (bus.io_keys_o !== m_out()) begin
        errors++;
        $display("FAIL random cyc %0d got %h exp %h", c, bus.io_keys_o, m_out());
      end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_press_latency();
    test_bounce();
    test_release_clear();
    test_clr_held();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
